// File: rtl/wptr_full_level.sv
// ---------------------------------------------------------------------------
// wptr_full_level
//
// Write-side pointer and status block of a dual-clock FIFO. Everything runs
// in the wclk domain. Keeps the binary and Gray write pointers, the
// registered full flag, an occupancy level computed against the synchronised
// read pointer, a programmable almost-full flag, the free-space count and a
// sticky overflow flag.
//
// Ports:
//   wclk          write clock, all state on its rising edge
//   wrst_n        asynchronous active-low reset
//   winc          write request
//   wq2_rptr      read Gray pointer, already synchronised into wclk
//   waf_thresh    almost-full threshold in entries (quasi-static)
//   wovf_clr      clear for the sticky overflow flag
//   wen           memory write enable (winc & ~wfull)
//   waddr         memory write address
//   wptr          registered Gray write pointer, to the read domain
//   wfull         registered full flag
//   walmost_full  registered almost-full flag (wlevel >= waf_thresh)
//   wlevel        registered occupancy seen from the write side, 0..DEPTH
//   wfree         DEPTH - wlevel
//   woverflow     sticky: a write was attempted while full
//
// Handshake: winc is a request, ~wfull acts as ready; a write is accepted
// exactly in a cycle where winc=1 and wfull=0 (wen=1). A request while full
// is dropped, the pointer holds, and woverflow is set.
// ---------------------------------------------------------------------------
module wptr_full_level #(
    parameter int ADDRSIZE = 4
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic [ADDRSIZE:0]   waf_thresh,
    input  logic                wovf_clr,
    output logic                wen,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic [ADDRSIZE:0]   wfree,
    output logic                woverflow
);

    localparam int              DEPTH   = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] DEPTH_W = DEPTH[ADDRSIZE:0];

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] wlevel_next;
    logic              wfull_next;
    logic              walmost_full_next;

    // wfull is registered, so wen never depends on wq2_rptr combinationally.
    assign wen   = winc & ~wfull;
    assign waddr = wbin[ADDRSIZE-1:0];
    assign wfree = DEPTH_W - wlevel;

    assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wen};
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;

    // Gray to binary: each bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin = '0;
        rbin[ADDRSIZE] = wq2_rptr[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ wq2_rptr[i];
        end
    end

    // Modular difference; the extra pointer bit lets a full FIFO read DEPTH.
    assign wlevel_next = wbinnext - rbin;

    // Full when the next write pointer equals the read pointer with the two
    // MSBs inverted (Gray form of "one lap ahead").
    assign wfull_next = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                       wq2_rptr[ADDRSIZE-2:0]});

    assign walmost_full_next = (wlevel_next >= waf_thresh);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= wfull_next;
            walmost_full <= walmost_full_next;
            wlevel       <= wlevel_next;
        end
    end

    // Set has priority over clear so an overflow in the clearing cycle is
    // not lost.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            woverflow <= 1'b0;
        end else if (winc & wfull) begin
            woverflow <= 1'b1;
        end else if (wovf_clr) begin
            woverflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wptr_full_level.sv
module tb_wptr_full_level;

    localparam int A     = 4;
    localparam int DEPTH = 1 << A;

    // ---------------- clock / reset ----------------
    logic         wclk = 1'b0;
    logic         wrst_n = 1'b0;
    logic         winc = 1'b0;
    logic [A:0]   wq2_rptr = '0;
    logic [A:0]   waf_thresh = '0;
    logic         wovf_clr = 1'b0;
    logic         wen;
    logic [A-1:0] waddr;
    logic [A:0]   wptr;
    logic         wfull;
    logic         walmost_full;
    logic [A:0]   wlevel;
    logic [A:0]   wfree;
    logic         woverflow;

    always #5 wclk = ~wclk;

    wptr_full_level #(.ADDRSIZE(A)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
        .waf_thresh(waf_thresh), .wovf_clr(wovf_clr), .wen(wen),
        .waddr(waddr), .wptr(wptr), .wfull(wfull),
        .walmost_full(walmost_full), .wlevel(wlevel), .wfree(wfree),
        .woverflow(woverflow)
    );

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [A:0]   ptr;
        logic [A-1:0] addr;
        logic         full;
        logic         af;
        logic [A:0]   level;
        logic [A:0]   free;
        logic         ovf;
    } exp_t;
    localparam int EW = $bits(exp_t);
    logic [EW-1:0] exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model: plain counts of entries written and read.
    int   wr_cnt = 0;
    int   rd_cnt = 0;
    logic m_full = 1'b0;
    logic m_ovf  = 1'b0;
    int   thr_next = 12;

    function automatic logic [A:0] gray(input int n);
        logic [31:0] v;
        logic [A:0]  b;
        v = n;
        b = v[A:0];
        return (b >> 1) ^ b;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic w, input int radv, input logic clr);
        int   lvl;
        int   r;
        exp_t e;
        @(negedge wclk);
        r = radv;
        if (r > wr_cnt - rd_cnt) r = wr_cnt - rd_cnt;
        rd_cnt    += r;
        winc       = w;
        wovf_clr   = clr;
        wq2_rptr   = gray(rd_cnt);
        waf_thresh = thr_next[A:0];
        #1;
        check("wen", {31'd0, wen}, {31'd0, w & ~m_full});
        if (w && m_full) m_ovf = 1'b1;
        else if (clr)    m_ovf = 1'b0;
        if (w && !m_full) wr_cnt++;
        lvl    = wr_cnt - rd_cnt;
        m_full = (lvl == DEPTH);
        e.ptr   = gray(wr_cnt);
        e.addr  = 4'(wr_cnt % DEPTH);
        e.full  = m_full;
        e.af    = (lvl >= thr_next);
        e.level = 5'(lvl);
        e.free  = 5'(DEPTH - lvl);
        e.ovf   = m_ovf;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge wclk);
        #2;
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wptr"},  wptr, 0);
        check({tag, "_waddr"}, waddr, 0);
        check({tag, "_wlevel"}, wlevel, 0);
        check({tag, "_wfree"}, wfree, DEPTH);
        check({tag, "_wfull"}, wfull, 0);
        check({tag, "_waf"},   walmost_full, 0);
        check({tag, "_wovf"},  woverflow, 0);
    endtask

    task automatic apply_reset();
        drain();
        winc     = 1'b0;
        wovf_clr = 1'b0;
        wq2_rptr = '0;
        wrst_n   = 1'b0;
        wr_cnt = 0; rd_cnt = 0; m_full = 1'b0; m_ovf = 1'b0;
        repeat (2) @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(posedge wclk) begin
        exp_t e;
        #1;
        if (wrst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wptr",   wptr, e.ptr);
            check("waddr",  waddr, e.addr);
            check("wfull",  wfull, e.full);
            check("walmost_full", walmost_full, e.af);
            check("wlevel", wlevel, e.level);
            check("wfree",  wfree, e.free);
            check("woverflow", woverflow, e.ovf);
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset held while winc toggles.
        for (int i = 0; i < 3; i++) begin
            @(negedge wclk);
            winc = i[0];
            #1;
            check_reset_vals("rst_hold");
        end
        @(negedge wclk);
        winc   = 1'b0;
        wrst_n = 1'b1;

        // Almost-full at 12, fill to full, overflow.
        thr_next = 12;
        for (int i = 0; i < 11; i++) cycle(1, 0, 0);
        cycle(1, 0, 0);                 // 12th write: almost-full sets
        cycle(0, 1, 0);                 // read advance: level 11, flag drops
        for (int i = 0; i < 5; i++) cycle(1, 0, 0);   // level 16
        cycle(1, 0, 0);                 // dropped, overflow set
        cycle(0, 0, 1);                 // clear
        cycle(1, 0, 0);                 // overflow again
        cycle(1, 0, 1);                 // set wins over clear
        cycle(0, 0, 1);                 // clear

        // Simultaneous write and read at level 15.
        cycle(0, 1, 0);
        cycle(1, 1, 0);
        cycle(0, 0, 0);

        // Threshold extremes.
        thr_next = 0;
        for (int i = 0; i < 3; i++) cycle(0, 2, 0);
        thr_next = 20;
        for (int i = 0; i < 20; i++) cycle(1, 0, 0);

        // Wrap: read tracks two behind for 40 writes.
        apply_reset();
        thr_next = 16;
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        for (int i = 0; i < 40; i++) cycle(1, 1, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) thr_next = $urandom_range(0, 2 * DEPTH - 1);
            cycle(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 3),
                  ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
        end

        // Fill, then asynchronous reset in the middle of the high phase.
        for (int i = 0; i < 20; i++) cycle(1, 0, 0);
        drain();
        @(posedge wclk);
        #3;
        wrst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        wr_cnt = 0; rd_cnt = 0; m_full = 1'b0; m_ovf = 1'b0;
        winc = 1'b0; wovf_clr = 1'b0; wq2_rptr = '0;
        @(negedge wclk);
        wrst_n = 1'b1;
        thr_next = 4;
        for (int i = 0; i < 6; i++) cycle(1, 0, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
